// File: rtl/ram2_arbiter_pkg.sv
// Shared definitions for the RAM2 arbiter: FSM state encoding, requester IDs
// and the default upper SRAM address bits.
package ram2_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ADDR  = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam logic [1:0] ADDR_HI_DEFAULT = 2'b00;

endpackage

// File: rtl/ram2_arb_grant.sv
// Grant selection between IF and MEM. Optional macro RAM2_ARB_RR_EN selects
// round-robin on contention; otherwise MEM has fixed priority over IF.
module ram2_arb_grant
    import ram2_arbiter_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic if_req,
    input  logic mem_req,
    input  logic grant_en,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = if_req | mem_req;

`ifdef RAM2_ARB_RR_EN
    // Requester served by the most recent grant; reset to IF so MEM wins first.
    logic last_id;

    always_comb begin
        gnt_id = REQ_IF;
        if (if_req && mem_req) begin
            gnt_id = ~last_id;
        end else if (mem_req) begin
            gnt_id = REQ_MEM;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_id <= REQ_IF;
        end else if (grant_en && gnt_valid) begin
            last_id <= gnt_id;
        end
    end
`else
    logic unused_grant_inputs;
    assign unused_grant_inputs = CLK ^ RST ^ grant_en;
    assign gnt_id = mem_req ? REQ_MEM : REQ_IF;
`endif

endmodule

// File: rtl/ram2_arbiter.sv
// Shares the RAM2 SRAM between instruction fetch and data accesses, sequencing
// EN/OE/WE, address and data drive. Optional macro: RAM2_ARB_RR_EN (round-robin).
module ram2_arbiter
    import ram2_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int WR_PULSE_CYC = 1,
    parameter logic [ADDR_W-17:0] ADDR_HI = ADDR_HI_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [15:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram2OE,
    output logic              ram2WE,
    output logic              ram2EN,
    output logic [ADDR_W-1:0] ram2Addr,
    inout  wire  [DATA_W-1:0] ram2Data,
    output logic [2:0]        dbg_state
);

    localparam logic [1:0] PULSE_LOAD = 2'(WR_PULSE_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic [1:0]        pulse_cnt;
    logic              cur_id;
    logic [DATA_W-1:0] cur_wdata;
    logic              gnt_valid;
    logic              gnt_id;
    logic              wr_drive;

    ram2_arb_grant u_grant (
        .CLK       (CLK),
        .RST       (RST),
        .if_req    (if_req),
        .mem_req   (mem_req),
        .grant_en  (state == ST_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Bus is driven only in the write states, where OE is held high.
    assign wr_drive  = (state == ST_WR_SETUP) || (state == ST_WR_PULSE) || (state == ST_WR_HOLD);
    assign ram2Data  = wr_drive ? cur_wdata : {DATA_W{1'bz}};
    assign dbg_state = state;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    next_state = (gnt_id == REQ_MEM && mem_we) ? ST_WR_SETUP : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR:  next_state = ST_RD_DATA;
            ST_RD_DATA:  next_state = ST_DONE;
            ST_WR_SETUP: next_state = ST_WR_PULSE;
            ST_WR_PULSE: next_state = (pulse_cnt == 2'd0) ? ST_WR_HOLD : ST_WR_PULSE;
            ST_WR_HOLD:  next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Pin and ready registers are decoded from next_state so they line up with state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            pulse_cnt <= 2'd0;
            cur_id    <= REQ_IF;
            cur_wdata <= '0;
            ram2EN    <= 1'b1;
            ram2OE    <= 1'b1;
            ram2WE    <= 1'b1;
            ram2Addr  <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= next_state;
            ram2EN    <= (next_state == ST_IDLE) || (next_state == ST_DONE);
            ram2OE    <= !((next_state == ST_RD_ADDR) || (next_state == ST_RD_DATA));
            ram2WE    <= (next_state != ST_WR_PULSE);
            if_ready  <= (next_state == ST_DONE) && (cur_id == REQ_IF);
            mem_ready <= (next_state == ST_DONE) && (cur_id == REQ_MEM);

            if (state == ST_WR_SETUP) begin
                pulse_cnt <= PULSE_LOAD;
            end else if (state == ST_WR_PULSE && pulse_cnt != 2'd0) begin
                pulse_cnt <= pulse_cnt - 2'd1;
            end

            if (state == ST_IDLE && gnt_valid) begin
                cur_id    <= gnt_id;
                cur_wdata <= mem_wdata;
                ram2Addr  <= {ADDR_HI, (gnt_id == REQ_MEM) ? mem_addr : if_addr};
            end

            if (state == ST_RD_DATA) begin
                if (cur_id == REQ_MEM) begin
                    mem_rdata <= ram2Data;
                end else begin
                    if_rdata <= ram2Data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram2_arbiter.sv
// Self-checking bench for ram2_arbiter: SRAM model, request drivers, a
// scoreboard with per-port expected queues, and a final report.
module tb_ram2_arbiter;

    localparam int P     = 2;
    localparam int BOUND = 500;

    logic        CLK;
    logic        RST;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        ram2OE;
    logic        ram2WE;
    logic        ram2EN;
    logic [17:0] ram2Addr;
    wire  [15:0] ram2Data;
    logic [2:0]  dbg_state;

    ram2_arbiter #(.WR_PULSE_CYC(P)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ram2OE    (ram2OE),
        .ram2WE    (ram2WE),
        .ram2EN    (ram2EN),
        .ram2Addr  (ram2Addr),
        .ram2Data  (ram2Data),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- SRAM model ----------------
    logic [15:0] sram    [0:65535];
    logic        sram_wr [0:65535];
    logic [15:0] ref_mem [0:65535];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0040) return 16'h0800;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] sram_peek(input logic [15:0] a);
        return (sram_wr[a] === 1'b1) ? sram[a] : init_val(a);
    endfunction

    assign ram2Data = (!ram2EN && !ram2OE) ? sram_peek(ram2Addr[15:0]) : 16'hzzzz;

    always @(posedge CLK) begin
        if (!ram2EN && !ram2WE) begin
            sram[ram2Addr[15:0]]    <= ram2Data;
            sram_wr[ram2Addr[15:0]] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] if_exp_q[$];
    logic [16:0] mem_exp_q[$];
    logic        order_q[$];
    logic [15:0] if_done_val  = 16'h0;
    logic [15:0] mem_done_val = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            check("both_ready", {31'b0, if_ready && mem_ready}, 32'd0);
            check("we_low_with_oe_low", {31'b0, !ram2WE && !ram2OE}, 32'd0);
            if (if_ready) begin
                order_q.push_back(1'b0);
                check("if_ready_req_held", {31'b0, if_req}, 32'd1);
                n_vec++;
                if (if_exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL if_unexpected_ready: got ready with %0d pending expected >0", if_exp_q.size());
                end else begin
                    if_done_val = if_exp_q.pop_front();
                    check("if_rdata", {16'b0, if_rdata}, {16'b0, if_done_val});
                    check("mem_rdata_kept_by_if", {16'b0, mem_rdata}, {16'b0, mem_done_val});
                end
            end
            if (mem_ready) begin
                logic [16:0] e;
                order_q.push_back(1'b1);
                check("mem_ready_req_held", {31'b0, mem_req}, 32'd1);
                n_vec++;
                if (mem_exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL mem_unexpected_ready: got ready with %0d pending expected >0", mem_exp_q.size());
                end else begin
                    e = mem_exp_q.pop_front();
                    if (!e[16]) mem_done_val = e[15:0];
                    check("mem_rdata", {16'b0, mem_rdata}, {16'b0, mem_done_val});
                    check("if_rdata_kept_by_mem", {16'b0, if_rdata}, {16'b0, if_done_val});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input logic port_mem, input logic [15:0] wdata,
                             output int lat, output int oe_lo, output int we_lo,
                             output int drv, output logic [17:0] addr2);
        lat = 0; oe_lo = 0; we_lo = 0; drv = 0; addr2 = '0;
        for (int i = 1; i <= BOUND; i++) begin
            @(negedge CLK);
            if (i == 2) addr2 = ram2Addr;
            if (!ram2OE) oe_lo++;
            if (!ram2WE) we_lo++;
            if (!ram2EN && ram2OE && ram2Data == wdata) drv++;
            if (port_mem ? mem_ready : if_ready) begin
                lat = i;
                break;
            end
        end
        n_vec++;
        if (lat == 0) begin
            n_err++;
            $display("FAIL ready_timeout: port %0d got no ready within %0d cycles", port_mem, BOUND);
        end
    endtask

    task automatic if_xact(input logic [15:0] addr, output int lat, output int oe_lo,
                           output logic [17:0] addr2);
        int we_lo, drv;
        if_exp_q.push_back(ref_mem[addr]);
        if_addr = addr;
        if_req  = 1'b1;
        wait_done(1'b0, 16'h0, lat, oe_lo, we_lo, drv, addr2);
        @(posedge CLK);
        #1 if_req = 1'b0;
    endtask

    task automatic mem_xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            output int lat, output int oe_lo, output int we_lo, output int drv);
        logic [17:0] addr2;
        mem_exp_q.push_back({we, we ? 16'h0 : ref_mem[addr]});
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_req   = 1'b1;
        wait_done(1'b1, wdata, lat, oe_lo, we_lo, drv, addr2);
        if (we && lat != 0) ref_mem[addr] = wdata;
        @(posedge CLK);
        #1 mem_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int          lat_a, lat_b, oe_a, oe_b, we_a, drv_a;
    logic [17:0] a2;
    logic [15:0] old_val;
    logic        found;
    logic        exp_order[8];

    initial begin
        for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(16'(a));
        RST = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_en", {31'b0, ram2EN}, 32'd1);
        check("rst_oe", {31'b0, ram2OE}, 32'd1);
        check("rst_we", {31'b0, ram2WE}, 32'd1);
        check("rst_addr", {14'b0, ram2Addr}, 32'd0);
        check("rst_readies", {30'b0, if_ready, mem_ready}, 32'd0);
        check("rst_rdata", {if_rdata, mem_rdata}, 32'd0);
        @(posedge CLK); #1 RST = 1'b1;
        repeat (2) @(posedge CLK); #1;

        // IF read
        if_xact(16'h0040, lat_a, oe_a, a2);
        check("if_rd_latency", lat_a, 32'd4);
        check("if_rd_addr", {14'b0, a2}, 32'h00040);
        check("if_rd_oe_low_cycles", oe_a, 32'd2);
        @(negedge CLK);
        check("if_rd_single_pulse", {31'b0, if_ready}, 32'd0);
        @(posedge CLK); #1;

        // MEM write
        mem_xact(1'b1, 16'h4001, 16'hBEEF, lat_a, oe_a, we_a, drv_a);
        check("mem_wr_latency", lat_a, 32'(4 + P));
        check("mem_wr_we_low_cycles", we_a, 32'(P));
        check("mem_wr_oe_low_cycles", oe_a, 32'd0);
        check("mem_wr_data_driven_cycles", drv_a, 32'(P + 2));
        check("mem_wr_sram", {16'b0, sram_peek(16'h4001)}, 32'h0000BEEF);

        // Reset in the middle of a write pulse
        old_val = sram_peek(16'h4100);
        mem_we = 1'b1; mem_addr = 16'h4100; mem_wdata = 16'h1234; mem_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!ram2WE) begin found = 1'b1; break; end
        end
        check("rst_mid_reached_pulse", {31'b0, found}, 32'd1);
        RST = 1'b0;
        #1;
        check("rst_mid_we", {31'b0, ram2WE}, 32'd1);
        check("rst_mid_en", {31'b0, ram2EN}, 32'd1);
        check("rst_mid_oe", {31'b0, ram2OE}, 32'd1);
        check("rst_mid_readies", {30'b0, if_ready, mem_ready}, 32'd0);
        check("rst_mid_rdata", {if_rdata, mem_rdata}, 32'd0);
        mem_req = 1'b0;
        mem_exp_q.delete(); if_exp_q.delete();
        if_done_val = 16'h0; mem_done_val = 16'h0;
        @(posedge CLK); #1 RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_mid_idle_en", {31'b0, ram2EN}, 32'd1);
        end
        check("rst_mid_sram_untouched", {16'b0, sram_peek(16'h4100)}, {16'b0, old_val});
        @(posedge CLK); #1;

        // Simultaneous requests: MEM served first, IF 4 cycles later
        fork
            mem_xact(1'b0, 16'h4001, 16'h0, lat_a, oe_b, we_a, drv_a);
            if_xact(16'h0041, lat_b, oe_a, a2);
        join
        check("simul_mem_latency", lat_a, 32'd4);
        check("simul_if_latency", lat_b, 32'd8);

        // Continuous contention, grant order
        order_q.delete();
        fork
            begin
                int l, o, w, d;
                for (int i = 0; i < 4; i++) mem_xact(1'b0, 16'(16'h4010 + i), 16'h0, l, o, w, d);
            end
            begin
                int l, o;
                logic [17:0] x;
                for (int i = 0; i < 4; i++) if_xact(16'(16'h0010 + i), l, o, x);
            end
        join
`ifdef RAM2_ARB_RR_EN
        for (int i = 0; i < 8; i++) exp_order[i] = (i % 2 == 0);
`else
        for (int i = 0; i < 8; i++) exp_order[i] = (i < 4);
`endif
        check("order_count", order_q.size(), 32'd8);
        for (int i = 0; i < 8 && i < order_q.size(); i++)
            check($sformatf("grant_order[%0d]", i), {31'b0, order_q[i]}, {31'b0, exp_order[i]});

        // Random mixed traffic
        fork
            begin
                int l, o, w, d;
                for (int i = 0; i < 500; i++) begin
                    mem_xact(1'($urandom_range(0, 1)), 16'(16'h4000 + $urandom_range(0, 63)),
                             16'($urandom), l, o, w, d);
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                end
            end
            begin
                int l, o;
                logic [17:0] x;
                for (int i = 0; i < 500; i++) begin
                    if_xact(16'($urandom_range(0, 63)), l, o, x);
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                end
            end
        join
        repeat (3) @(negedge CLK);
        check("if_queue_drained", if_exp_q.size(), 32'd0);
        check("mem_queue_drained", mem_exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
